// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC fetch controller.
// The optional redirect/drop statistics are enabled by PC_FETCH_REDIRECT_STATS_EN.
package pc_fetch_pkg;
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_INCR = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority select: jump > branch (pcsrc) > sequential increment > hold.
module pc_next_sel import pc_fetch_pkg::*; #(
  parameter int PC_W = 32
) (
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            pcsrc,
  input  logic [PC_W-1:0] branch_target,
  input  logic            inc_en,
  input  logic [PC_W-1:0] inc_base,
  input  logic [PC_W-1:0] cur_pc,
  output logic [PC_W-1:0] next_pc,
  output logic            redirect
);
  always_comb begin
    redirect = jump | pcsrc;
    if (jump) begin
      next_pc = jump_target;
    end else if (pcsrc) begin
      next_pc = branch_target;
    end else if (inc_en) begin
      // Wraps silently at 2^PC_W.
      next_pc = inc_base + PC_W'(PC_INCR);
    end else begin
      next_pc = cur_pc;
    end
  end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter owner and single-outstanding instruction fetch controller.
// Optional saturating redirect/drop counters are enabled by PC_FETCH_REDIRECT_STATS_EN.
module pc_fetch_ctrl import pc_fetch_pkg::*; #(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pcsrc,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               jump,
  input  logic [PC_W-1:0]    jump_target,
  input  logic               stall,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               flush_out,
  output fetch_state_t       state_dbg
`ifdef PC_FETCH_REDIRECT_STATS_EN
  ,
  output logic [15:0]        redirect_count,
  output logic [15:0]        dropped_count
`endif
);
  // Handshakes: a request transfers on imem_req_valid && imem_req_ready;
  // a response is a single-cycle imem_rsp_valid pulse, honoured only in S_WAIT;
  // decode consumes instr in a cycle with instr_valid && !stall.

  fetch_state_t    state, state_n;
  logic [PC_W-1:0] pc, fetch_pc, next_pc;
  logic            drop, redirect, hs, rsp_w, accept;

  assign hs     = imem_req_valid & imem_req_ready;
  assign rsp_w  = (state == S_WAIT) & imem_rsp_valid;
  assign accept = rsp_w & ~drop & ~redirect;

  pc_next_sel #(.PC_W(PC_W)) u_next_sel (
    .jump          (jump),
    .jump_target   (jump_target),
    .pcsrc         (pcsrc),
    .branch_target (branch_target),
    .inc_en        (accept),
    .inc_base      (fetch_pc),
    .cur_pc        (pc),
    .next_pc       (next_pc),
    .redirect      (redirect)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_REQ;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_REQ:   if (hs) state_n = S_WAIT;
      S_WAIT:  if (imem_rsp_valid) state_n = (accept && stall) ? S_HOLD : S_REQ;
      S_HOLD:  if (redirect || !stall) state_n = S_REQ;
      default: state_n = S_REQ;
    endcase
  end

  // No request is shown while reset is held, so the first one appears the cycle after release.
  always_comb begin
    imem_req_valid = ~reset & (state == S_REQ);
    imem_addr      = pc;
    state_dbg      = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      fetch_pc    <= RESET_PC;
      drop        <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      flush_out   <= 1'b0;
    end else begin
      pc        <= next_pc;
      flush_out <= redirect;
      if (hs) fetch_pc <= pc;
      // A redirect while a fetch is in flight marks its response as wrong-path.
      if (rsp_w)                                     drop <= 1'b0;
      else if (redirect && (hs || state == S_WAIT)) drop <= 1'b1;
      if (accept) begin
        instr       <= imem_rsp_data;
        instr_pc    <= fetch_pc;
        instr_valid <= 1'b1;
      end else if (state == S_HOLD && redirect) begin
        instr_valid <= 1'b0;
      end else if (instr_valid && !stall) begin
        instr_valid <= 1'b0;
      end
    end
  end

`ifdef PC_FETCH_REDIRECT_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_count <= '0;
      dropped_count  <= '0;
    end else begin
      if (redirect && redirect_count != 16'hFFFF) redirect_count <= redirect_count + 16'd1;
      if (rsp_w && !accept && dropped_count != 16'hFFFF) dropped_count <= dropped_count + 16'd1;
    end
  end
`endif
endmodule
